// File: rtl/mont_redc.sv
// mont_redc: bit-serial Montgomery reduction, rd_out = num_in * 2^(-len) mod modulus.
// It converts values out of the Montgomery domain, using the same start/end handshake as
// long_div.
//
// Optional feature: define MONT_REDC_ERR_EN to add the rd_err port and the odd-modulus check.
//
// Ports:
//   clk       rising-edge clock
//   rstn      asynchronous active-low reset
//   rd_start  start request, level-sampled in IDLE/DONE
//   len       number of halving iterations (log2 R)
//   num_in    Montgomery-form value (num_in < modulus)
//   modulus   odd modulus, > 0
//   rd_err    bad (even or zero) modulus flag (MONT_REDC_ERR_EN only)
//   rd_end    result valid, held high in DONE
//   rd_out    reduced result, held in DONE
module mont_redc #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             rd_start,
    input  logic [LEN_W-1:0] len,
    input  logic [WIDTH-1:0] num_in,
    input  logic [WIDTH-1:0] modulus,
`ifdef MONT_REDC_ERR_EN
    output logic             rd_err,
`endif
    output logic             rd_end,
    output logic [WIDTH-1:0] rd_out
);

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mod_q, mod_d;
    logic             end_q, end_d;
    logic [WIDTH-1:0] out_q, out_d;
`ifdef MONT_REDC_ERR_EN
    logic             err_q, err_d;
`endif

    // acc stays below 2^(WIDTH+1), so acc + mod needs WIDTH+2 bits before halving.
    logic [WIDTH+1:0] sum;
    logic [WIDTH:0]   diff;
    logic             unused_bits;

    assign sum         = {1'b0, acc_q} + {2'b00, mod_q};
    assign diff        = acc_q - {1'b0, mod_q};
    assign unused_bits = ^{sum[0], diff[WIDTH]};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mod_d   = mod_q;
        end_d   = end_q;
        out_d   = out_q;
`ifdef MONT_REDC_ERR_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                if (rd_start) begin
                    acc_d   = {1'b0, num_in};
                    mod_d   = modulus;
                    cnt_d   = len;
                    end_d   = 1'b0;
                    state_d = (len == '0) ? StFix : StRun;
`ifdef MONT_REDC_ERR_EN
                    err_d   = 1'b0;
                    // Even modulus (including zero) has no inverse of 2: skip the iterations.
                    if (!modulus[0]) begin
                        state_d = StFix;
                    end
`endif
                end
            end
            StRun: begin
                // Add the modulus when odd so the halving is exact mod m.
                if (acc_q[0]) begin
                    acc_d = sum[WIDTH+1:1];
                end else begin
                    acc_d = {1'b0, acc_q[WIDTH:1]};
                end
                cnt_d = cnt_q - LEN_W'(1);
                if (cnt_q <= LEN_W'(1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                out_d   = (acc_q >= {1'b0, mod_q}) ? diff[WIDTH-1:0] : acc_q[WIDTH-1:0];
`ifdef MONT_REDC_ERR_EN
                if (!mod_q[0]) begin
                    out_d = '0;
                    err_d = 1'b1;
                end
`endif
                end_d   = 1'b1;
                state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            mod_q   <= '0;
            end_q   <= 1'b0;
            out_q   <= '0;
`ifdef MONT_REDC_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mod_q   <= mod_d;
            end_q   <= end_d;
            out_q   <= out_d;
`ifdef MONT_REDC_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    assign rd_end = end_q;
    assign rd_out = out_q;
`ifdef MONT_REDC_ERR_EN
    assign rd_err = err_q;
`endif

endmodule

// File: tb/tb_mont_redc.sv
module tb_mont_redc;

    logic        clk;
    logic        rstn;
    logic        rd_start;
    logic [7:0]  len;
    logic [31:0] num_in;
    logic [31:0] modulus;
    logic        rd_end;
    logic [31:0] rd_out;
`ifdef MONT_REDC_ERR_EN
    logic        rd_err;
`endif

    mont_redc #(.WIDTH(32), .LEN_W(8)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rd_start (rd_start),
        .len      (len),
        .num_in   (num_in),
        .modulus  (modulus),
`ifdef MONT_REDC_ERR_EN
        .rd_err   (rd_err),
`endif
        .rd_end   (rd_end),
        .rd_out   (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] out;
        logic        err;
        logic        chk_out;
        int unsigned cyc;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        end_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare on every rising edge of rd_end.
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            end_prev = 1'b0;
        end else begin
            if (rd_end && !end_prev) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_end actual=1 expected=0 (t=%0t)", $time);
                end else begin
                    e = sb_q.pop_front();
                    check("latency_cycle", cyc, e.cyc);
                    if (e.chk_out) check("rd_out", rd_out, e.out);
`ifdef MONT_REDC_ERR_EN
                    check("rd_err", {31'b0, rd_err}, {31'b0, e.err});
`endif
                end
            end
            end_prev = rd_end;
        end
    end

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout pending=%0d expected=0", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    // lat = edges from (and including) the start edge to the rd_end edge.
    task automatic run_op(input logic [31:0] n, input logic [31:0] m, input logic [7:0] l,
                          input logic [31:0] eo, input logic ee, input logic co,
                          input int unsigned lat);
        @(negedge clk);
        num_in   = n;
        modulus  = m;
        len      = l;
        rd_start = 1'b1;
        sb_q.push_back('{out: eo, err: ee, chk_out: co, cyc: cyc + lat});
        @(negedge clk);
        rd_start = 1'b0;
        num_in   = 32'h5A5A_5A5A;
        modulus  = 32'h0000_0003;
        len      = 8'd1;
        wait_drain(int'(lat) + 8);
    endtask

    initial begin
        rstn     = 1'b0;
        rd_start = 1'b0;
        len      = '0;
        num_in   = '0;
        modulus  = '0;
        repeat (3) @(negedge clk);
        check("reset_rd_end", {31'b0, rd_end}, 32'd0);
        check("reset_rd_out", rd_out, 32'd0);
`ifdef MONT_REDC_ERR_EN
        check("reset_rd_err", {31'b0, rd_err}, 32'd0);
`endif
        rstn = 1'b1;
        @(negedge clk);

        // Directed vectors, results worked by hand.
        run_op(32'd6, 32'd11, 8'd4, 32'd10, 1'b0, 1'b1, 6);
        run_op(32'd10, 32'd13, 8'd4, 32'd12, 1'b0, 1'b1, 6);
        run_op(32'd9, 32'd11, 8'd0, 32'd9, 1'b0, 1'b1, 2);
        run_op(32'd0, 32'd7, 8'd3, 32'd0, 1'b0, 1'b1, 5);
        run_op(32'd1, 32'd7, 8'd3, 32'd1, 1'b0, 1'b1, 5);
        run_op(32'd3, 32'd5, 8'd2, 32'd2, 1'b0, 1'b1, 4);
        // 2^32 == 1 mod (2^32-1), so the value is unchanged.
        run_op(32'hFFFF_FFFE, 32'hFFFF_FFFF, 8'd32, 32'hFFFF_FFFE, 1'b0, 1'b1, 34);
        // len > WIDTH: 2^-40 mod 3 == 1.
        run_op(32'd1, 32'd3, 8'd40, 32'd1, 1'b0, 1'b1, 42);

        // rd_start pulsed during RUN is ignored: 6 * 2^-8 mod 11 == 2.
        @(negedge clk);
        num_in = 32'd6; modulus = 32'd11; len = 8'd8; rd_start = 1'b1;
        sb_q.push_back('{out: 32'd2, err: 1'b0, chk_out: 1'b1, cyc: cyc + 10});
        @(negedge clk);
        rd_start = 1'b0;
        repeat (2) @(negedge clk);
        num_in = 32'd1; modulus = 32'd5; len = 8'd0; rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        wait_drain(20);

        // rd_start held high: back-to-back operations from DONE.
        @(negedge clk);
        num_in = 32'd10; modulus = 32'd13; len = 8'd4; rd_start = 1'b1;
        sb_q.push_back('{out: 32'd12, err: 1'b0, chk_out: 1'b1, cyc: cyc + 6});
        sb_q.push_back('{out: 32'd12, err: 1'b0, chk_out: 1'b1, cyc: cyc + 12});
        repeat (8) @(negedge clk);
        rd_start = 1'b0;
        wait_drain(16);

        // Reset mid-operation: rd_out holds 12 from before, must drop to 0 at once.
        @(negedge clk);
        num_in = 32'd6; modulus = 32'd11; len = 8'd8; rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("midrun_reset_rd_end", {31'b0, rd_end}, 32'd0);
        check("midrun_reset_rd_out", rd_out, 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (12) @(negedge clk);
        check("after_reset_no_end", {31'b0, rd_end}, 32'd0);
        run_op(32'd6, 32'd11, 8'd4, 32'd10, 1'b0, 1'b1, 6);

`ifdef MONT_REDC_ERR_EN
        run_op(32'd3, 32'd10, 8'd2, 32'd0, 1'b1, 1'b1, 2);
        run_op(32'd3, 32'd0, 8'd5, 32'd0, 1'b1, 1'b1, 2);
        run_op(32'd1, 32'd7, 8'd3, 32'd1, 1'b0, 1'b1, 5);
`else
        // Bad modulus without checking: result undefined, timing still len+2.
        run_op(32'd3, 32'd10, 8'd2, 32'd0, 1'b0, 1'b0, 4);
        run_op(32'd3, 32'd0, 8'd5, 32'd0, 1'b0, 1'b0, 7);
        run_op(32'd1, 32'd7, 8'd3, 32'd1, 1'b0, 1'b1, 5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute guard against a hung run.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "global timeout");
    end

endmodule
